// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: drains an idle subsystem before removing its clock,
// restores it on request or debug force, and acknowledges each completed transition.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic gate_req_i,
    input  logic idle_i,
    input  logic force_on_i,
    output logic clk_en_o,
    output logic gated_o,
    output logic ack_o,
    output logic busy_o
);

    localparam int MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (IDLE_CYCLES < 1) begin : g_bad_idle
            $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
        end
        if (WAKE_CYCLES < 1) begin : g_bad_wake
            $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q, clk_en_d;
    logic             gated_q, gated_d;
    logic             ack_q, ack_d;

    // State register; outputs are registered from next-state decode so they change only at edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            gated_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            gated_q  <= gated_d;
            ack_q    <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (gate_req_i && idle_i && !force_on_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = IDLE_LOAD;
                end
            end
            ST_DRAIN: begin
                // Abort wins over completion in the final drain cycle
                if (!gate_req_i || !idle_i || force_on_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_GATED;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GATED: begin
                if (!gate_req_i || force_on_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                // Not abortable: a fresh request is only looked at once back in RUN
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        clk_en_d = (state_d != ST_GATED);
        gated_d  = (state_d == ST_GATED);
        ack_d    = ((state_q == ST_DRAIN) && (state_d == ST_GATED)) ||
                   ((state_q == ST_WAKE)  && (state_d == ST_RUN));
    end

    assign clk_en_o = clk_en_q;
    assign gated_o  = gated_q;
    assign ack_o    = ack_q;
    assign busy_o   = (state_q == ST_DRAIN) || (state_q == ST_WAKE);

endmodule
